// File: rtl/rf_pkg.sv
// Shared types and helpers for the register_file_np slice.
package rf_pkg;

  // INIT runs the zeroing sweep; READY serves user reads and writes.
  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_t;

  // Number of registers addressed by an address of the given width.
  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_bank.sv
// One DEPTH x DATA_W register bank with a single synchronous write port and a
// single registered read port. The read port returns the incoming write data
// when it targets the address being written in the same cycle (write-first).
module rf_bank
  import rf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic              i_rd_zero,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              w_bypass;

  assign w_bypass  = i_wr_en && (i_wr_addr == i_rd_addr);
  assign o_rd_data = r_rd_data;

  // Storage array: no reset so it maps onto RAM; the top-level sweep zeroes it.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read: forced to zero while clearing, otherwise load on enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_zero) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= w_bypass ? i_wr_data : r_mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/register_file_np.sv
// Parametrised register file: DEPTH registers, N_RD registered read ports and
// one write port. Each read port owns a full copy of the registers so every
// port can read independently; all copies receive the same writes. After reset
// or a clear request a sweep writes zero to every address before user writes
// are accepted.
module register_file_np
  import rf_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int N_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     w_en,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic [N_RD-1:0]          r_en,
  input  logic [N_RD*ADDR_W-1:0]   r_addr,
  output logic [N_RD*DATA_W-1:0]   r_data,
  output logic                     busy
);

  localparam int                DEPTH     = rf_depth(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         r_state;
  rf_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_busy;

  logic              w_bank_we;
  logic [ADDR_W-1:0] w_bank_waddr;
  logic [DATA_W-1:0] w_bank_wdata;
  logic              w_rd_zero;

  assign busy = r_busy;

  // Next-state logic and bank write-port mux between sweep and user port.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_bank_we    = 1'b0;
    w_bank_waddr = w_addr;
    w_bank_wdata = w_data;
    w_rd_zero    = 1'b0;
    case (r_state)
      RF_INIT: begin
        w_bank_we    = 1'b1;
        w_bank_waddr = r_cnt;
        w_bank_wdata = '0;
        w_rd_zero    = 1'b1;
        if (clear) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == LAST_ADDR) begin
          w_state_nxt = RF_READY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      RF_READY: begin
        if (clear) begin
          w_state_nxt = RF_INIT;
          w_cnt_nxt   = '0;
          w_rd_zero   = 1'b1;
        end else begin
          w_bank_we = w_en;
        end
      end
      default: begin
        w_state_nxt = RF_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, sweep counter and registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RF_INIT;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == RF_INIT);
    end
  end

  for (genvar p = 0; p < N_RD; p++) begin : g_bank
    rf_bank #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_bank_we),
      .i_wr_addr (w_bank_waddr),
      .i_wr_data (w_bank_wdata),
      .i_rd_en   (r_en[p]),
      .i_rd_zero (w_rd_zero),
      .i_rd_addr (r_addr[p*ADDR_W +: ADDR_W]),
      .o_rd_data (r_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: doc/register_file_np.md
# register_file_np

Parametrised successor to the LC-3 two-read-port register file. Provides DEPTH registers of DATA_W bits, N_RD independent registered read ports and one write port. Adds a write-first bypass and a hardware clear sequencer that zeroes every register after reset or on request, because the RAM-inferred banks cannot themselves be reset. Sits between decode (read addresses) and writeback (write port) in the datapath.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- N_RD, 2, number of read ports (≥1)
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  single-cycle request to re-zero all registers
- w_en  input  1  write enable
- w_addr  input  ADDR_W  write address
- w_data  input  DATA_W  write data
- r_en  input  N_RD  per-port read enable, bit p for port p
- r_addr  input  N_RD*ADDR_W  packed read addresses, port p at bits [p*ADDR_W +: ADDR_W]
- r_data  output  N_RD*DATA_W  packed registered read data, port p at bits [p*DATA_W +: DATA_W]
- busy  output  1  high while the clear sweep runs; user port ignored

## Operation
- FSM states: INIT (sweep), READY.
- Reset (rst_n low, asynchronous): state=INIT, sweep counter=0, busy=1, all r_data=0. Register contents are not touched by reset itself.
- INIT: each cycle writes 0 to address = counter in every bank, counter increments. After the write of address DEPTH-1, the next state is READY. Counter is ADDR_W+1 bits or uses a terminal compare; no wrap to 0 while in INIT.
- INIT: w_en is ignored and the write is dropped, not queued. All r_data are held at 0 regardless of r_en.
- READY: when w_en is high, w_data is written to w_addr in every bank at the clock edge.
- READY read, port p: when r_en[p] is high, r_data[p] <= registers[r_addr[p]] at the edge. When r_en[p] is low, r_data[p] holds its value.
- Bypass (write-first): in READY, if w_en is high, r_en[p] is high and r_addr[p]==w_addr in the same cycle, r_data[p] gets w_data. The original register file returned the old value in this case; this block returns the new one.
- Several ports reading the same address all receive identical data.
- clear in READY: next state INIT, counter=0, busy=1 from the next cycle. A w_en in the same cycle is dropped. r_data is forced to 0 from the next edge.
- clear during INIT: the counter restarts at 0, so the sweep takes the full DEPTH cycles again.
- Reset mid-sweep or mid-operation: same as power-up reset; the sweep restarts from address 0 after rst_n releases.

## Timing
- Read latency: 1 cycle, from address/enable sampled at edge n to data valid after edge n.
- Write latency: 1 cycle. A read issued the cycle after a write, without bypass, sees the new value.
- Sweep: the first rising edge with rst_n high writes address 0. busy is high through DEPTH edges and falls after edge DEPTH, which is 8 cycles for defaults. The first user write is accepted on edge DEPTH+1.
- busy is a registered output derived from the state, with no combinational path from clear.
- The clear-to-busy path is 1 cycle.

## Structure
- Shared package rf_pkg: state enum rf_state_t {RF_INIT, RF_READY}; localparam helper for DEPTH from ADDR_W.
- Sub-module rf_bank: one DEPTH×DATA_W bank with one synchronous write port, one registered read port, read enable and bypass compare. It is instantiated N_RD times in a generate loop.
- The top level holds the FSM and sweep counter, and muxes the bank write port between the sweep (address=counter, data=0) and the user port.

## Test plan
- Reset, then idle: busy=1 for exactly 8 cycles after rst_n rises. Afterwards, reading all 8 addresses on both ports returns 0x0000.
- Write 0x1234 to R3, then read R3 on port 0 and R5 on port 1 the next cycle: port 0=0x1234, port 1=0x0000.
- Same cycle w_en=1, w_addr=2, w_data=0xBEEF, r_addr0=2, r_addr1=2: both ports=0xBEEF after the edge (bypass).
- Write R1=0xAAAA, hold r_en=0 on port 1 while changing r_addr1: r_data1 holds its prior value. Then raise r_en: r_data1=0xAAAA.
- Fill R0–R7 with 0x1111·k, pulse clear together with a write of R4=0xFFFF: busy=1 for 8 cycles, the write is dropped, and all registers read 0x0000 afterwards.
- Assert rst_n low at cycle 4 of a sweep, release it: busy stays high for 8 full cycles after release and r_data=0 throughout.
